// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage data-memory access unit for the RV32I pipeline.
// Turns a decoded load/store into one request/grant/response bus transaction,
// stalls the pipeline while it is in flight, and returns formatted load data.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   m_mem_read, m_mem_write   MEM-stage load/store request (write wins if both)
//   bxx_flush                 branch flush, blocks the start of a new access
//   funct3, addr, wdata       access size/sign, byte address, store data
//   stall                     hold IF..MEM pipeline registers
//   rdata, rdata_valid        formatted load data and its one-cycle valid
//   access_err                misaligned / illegal-funct3 start (comb pulse)
//   bus_req/we/addr/be/wdata  registered request to the data bus
//   bus_gnt                   request accepted this cycle
//   bus_rvalid, bus_rdata     read response
module mem_access_unit #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m_mem_read,
    input  logic              m_mem_write,
    input  logic              bxx_flush,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              stall,
    output logic [DATA_W-1:0] rdata,
    output logic              rdata_valid,
    output logic              access_err,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [3:0]        bus_be,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_gnt,
    input  logic              bus_rvalid,
    input  logic [DATA_W-1:0] bus_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        WAIT_R = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic              bus_req_q, bus_req_d;
    logic              bus_we_q, bus_we_d;
    logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
    logic [3:0]        bus_be_q, bus_be_d;
    logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              rdata_valid_q, rdata_valid_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [1:0]        off_q, off_d;

    logic              is_write;
    logic              start;
    logic              legal;
    logic [3:0]        st_be;
    logic [DATA_W-1:0] st_wdata;
    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;
    logic [DATA_W-1:0] ld_data;

    // Start qualification and legality of the MEM-stage access.
    always_comb begin
        is_write = m_mem_write;
        start    = (m_mem_read | m_mem_write) & ~bxx_flush & ~rst;
        case (funct3)
            3'b000:         legal = 1'b1;
            3'b001:         legal = ~addr[0];
            3'b010:         legal = (addr[1:0] == 2'b00);
            // Unsigned variants exist only for loads.
            3'b100:         legal = ~is_write;
            3'b101:         legal = ~is_write & ~addr[0];
            default:        legal = 1'b0;
        endcase
    end

    // Store byte enables and lane-replicated store data.
    always_comb begin
        case (funct3[1:0])
            2'b00: begin
                st_be    = 4'b0001 << addr[1:0];
                st_wdata = DATA_W'({4{wdata[7:0]}});
            end
            2'b01: begin
                st_be    = addr[1] ? 4'b1100 : 4'b0011;
                st_wdata = DATA_W'({2{wdata[15:0]}});
            end
            default: begin
                st_be    = 4'b1111;
                st_wdata = wdata;
            end
        endcase
    end

    // Load lane select from the latched offset, then sign/zero extension.
    always_comb begin
        ld_byte = bus_rdata[{off_q, 3'b000} +: 8];
        ld_half = off_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        case (funct3_q)
            3'b000:  ld_data = DATA_W'({{24{ld_byte[7]}}, ld_byte});
            3'b100:  ld_data = DATA_W'({24'd0, ld_byte});
            3'b001:  ld_data = DATA_W'({{16{ld_half[15]}}, ld_half});
            3'b101:  ld_data = DATA_W'({16'd0, ld_half});
            default: ld_data = bus_rdata;
        endcase
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d       = state_q;
        bus_req_d     = bus_req_q;
        bus_we_d      = bus_we_q;
        bus_addr_d    = bus_addr_q;
        bus_be_d      = bus_be_q;
        bus_wdata_d   = bus_wdata_q;
        rdata_d       = rdata_q;
        rdata_valid_d = 1'b0;
        funct3_d      = funct3_q;
        off_d         = off_q;
        case (state_q)
            IDLE: begin
                if (start && legal) begin
                    bus_req_d   = 1'b1;
                    bus_we_d    = is_write;
                    bus_addr_d  = {addr[ADDR_W-1:2], 2'b00};
                    bus_be_d    = is_write ? st_be : 4'b1111;
                    bus_wdata_d = is_write ? st_wdata : '0;
                    funct3_d    = funct3;
                    off_d       = addr[1:0];
                    state_d     = REQ;
                end
            end
            REQ: begin
                if (bus_gnt) begin
                    bus_req_d = 1'b0;
                    state_d   = bus_we_q ? DONE : WAIT_R;
                end
            end
            WAIT_R: begin
                if (bus_rvalid) begin
                    rdata_d       = ld_data;
                    rdata_valid_d = 1'b1;
                    state_d       = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any in-flight transaction.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            bus_req_q     <= 1'b0;
            bus_we_q      <= 1'b0;
            bus_addr_q    <= '0;
            bus_be_q      <= 4'b0000;
            bus_wdata_q   <= '0;
            rdata_q       <= '0;
            rdata_valid_q <= 1'b0;
            funct3_q      <= 3'b000;
            off_q         <= 2'b00;
        end else begin
            state_q       <= state_d;
            bus_req_q     <= bus_req_d;
            bus_we_q      <= bus_we_d;
            bus_addr_q    <= bus_addr_d;
            bus_be_q      <= bus_be_d;
            bus_wdata_q   <= bus_wdata_d;
            rdata_q       <= rdata_d;
            rdata_valid_q <= rdata_valid_d;
            funct3_q      <= funct3_d;
            off_q         <= off_d;
        end
    end

    // The start cycle must stall and flag errors in the same cycle it is seen.
    assign stall       = ((state_q == IDLE) & start & legal) |
                         (state_q == REQ) | (state_q == WAIT_R);
    assign access_err  = (state_q == IDLE) & start & ~legal;

    assign bus_req     = bus_req_q;
    assign bus_we      = bus_we_q;
    assign bus_addr    = bus_addr_q;
    assign bus_be      = bus_be_q;
    assign bus_wdata   = bus_wdata_q;
    assign rdata       = rdata_q;
    assign rdata_valid = rdata_valid_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed, table-driven bench for mem_access_unit.
module tb_mem_access_unit;

    logic        clk;
    logic        rst;
    logic        m_mem_read;
    logic        m_mem_write;
    logic        bxx_flush;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall;
    logic [31:0] rdata;
    logic        rdata_valid;
    logic        access_err;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_gnt;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;

    int checks;
    int failures;

    mem_access_unit #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .m_mem_read  (m_mem_read),
        .m_mem_write (m_mem_write),
        .bxx_flush   (bxx_flush),
        .funct3      (funct3),
        .addr        (addr),
        .wdata       (wdata),
        .stall       (stall),
        .rdata       (rdata),
        .rdata_valid (rdata_valid),
        .access_err  (access_err),
        .bus_req     (bus_req),
        .bus_we      (bus_we),
        .bus_addr    (bus_addr),
        .bus_be      (bus_be),
        .bus_wdata   (bus_wdata),
        .bus_gnt     (bus_gnt),
        .bus_rvalid  (bus_rvalid),
        .bus_rdata   (bus_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        flush;      // flush in the start cycle
        logic        flush_mid;  // flush while the access is in flight
        int          gnt_dly;
        int          rv_dly;
        logic [31:0] rdata_in;
        logic        exp_err;
        logic [31:0] exp_addr;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        logic [31:0] exp_rdata;
    } vec_t;

    localparam int NVEC = 15;
    vec_t vecs [NVEC];

    task automatic chk(input int idx, input string name,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL v%0d %s: got 0x%08h, expected 0x%08h", idx, name, act, exp);
        end
    endtask

    task automatic chk_reset_outputs(input int idx);
        chk(idx, "rst_stall",  32'(stall), 32'd0);
        chk(idx, "rst_req",    32'(bus_req), 32'd0);
        chk(idx, "rst_we",     32'(bus_we), 32'd0);
        chk(idx, "rst_rvld",   32'(rdata_valid), 32'd0);
        chk(idx, "rst_err",    32'(access_err), 32'd0);
        chk(idx, "rst_addr",   bus_addr, 32'd0);
        chk(idx, "rst_be",     32'(bus_be), 32'd0);
        chk(idx, "rst_wdata",  bus_wdata, 32'd0);
        chk(idx, "rst_rdata",  rdata, 32'd0);
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        bit started;
        bit is_load;
        started = !v.flush && !v.exp_err;
        is_load = v.rd && !v.wr;
        @(negedge clk);
        m_mem_read  = v.rd;
        m_mem_write = v.wr;
        funct3      = v.f3;
        addr        = v.addr;
        wdata       = v.wdata;
        bxx_flush   = v.flush;
        #1;
        chk(idx, "err",         32'(access_err), 32'(v.exp_err));
        chk(idx, "stall_start", 32'(stall), 32'(started));
        chk(idx, "req_idle",    32'(bus_req), 32'd0);
        @(negedge clk);
        m_mem_read  = 1'b0;
        m_mem_write = 1'b0;
        bxx_flush   = v.flush_mid;
        if (!started) begin
            chk(idx, "req_none",   32'(bus_req), 32'd0);
            chk(idx, "stall_none", 32'(stall), 32'd0);
            chk(idx, "rvld_none",  32'(rdata_valid), 32'd0);
            bxx_flush = 1'b0;
            return;
        end
        for (int i = 0; i <= v.gnt_dly; i++) begin
            if (i > 0) @(negedge clk);
            chk(idx, "req_hi",    32'(bus_req), 32'd1);
            chk(idx, "stall_req", 32'(stall), 32'd1);
            chk(idx, "bus_addr",  bus_addr, v.exp_addr);
            chk(idx, "bus_be",    32'(bus_be), 32'(v.exp_be));
            chk(idx, "bus_we",    32'(bus_we), 32'(v.wr));
            if (v.wr) chk(idx, "bus_wdata", bus_wdata, v.exp_wdata);
            bus_gnt = (i == v.gnt_dly);
        end
        @(negedge clk);
        bus_gnt = 1'b0;
        if (is_load) begin
            for (int i = 0; i <= v.rv_dly; i++) begin
                if (i > 0) @(negedge clk);
                chk(idx, "req_wait",   32'(bus_req), 32'd0);
                chk(idx, "stall_wait", 32'(stall), 32'd1);
                chk(idx, "rvld_wait",  32'(rdata_valid), 32'd0);
                bus_rvalid = (i == v.rv_dly);
                bus_rdata  = (i == v.rv_dly) ? v.rdata_in : 32'h0BAD_0BAD;
            end
            @(negedge clk);
            bus_rvalid = 1'b0;
        end
        chk(idx, "stall_done", 32'(stall), 32'd0);
        chk(idx, "req_done",   32'(bus_req), 32'd0);
        chk(idx, "rvld_done",  32'(rdata_valid), 32'(is_load));
        if (is_load) chk(idx, "rdata", rdata, v.exp_rdata);
        bxx_flush = 1'b0;
        @(negedge clk);
        chk(idx, "rvld_after",  32'(rdata_valid), 32'd0);
        chk(idx, "stall_after", 32'(stall), 32'd0);
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        rst         = 1'b1;
        m_mem_read  = 1'b0;
        m_mem_write = 1'b0;
        bxx_flush   = 1'b0;
        funct3      = 3'b000;
        addr        = 32'h0;
        wdata       = 32'h0;
        bus_gnt     = 1'b0;
        bus_rvalid  = 1'b0;
        bus_rdata   = 32'h0;

        //            rd    wr    f3      addr        wdata         fl    flm  g  r  rdata_in      err   exp_addr    be     exp_wdata     exp_rdata
        vecs[0]  = '{1'b0, 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 1'b0, 1'b0, 2, 0, 32'h0,        1'b0, 32'h100, 4'hF, 32'hDEADBEEF, 32'h0};
        vecs[1]  = '{1'b0, 1'b1, 3'b000, 32'h203, 32'h000000A5, 1'b0, 1'b0, 0, 0, 32'h0,        1'b0, 32'h200, 4'h8, 32'hA5A5A5A5, 32'h0};
        vecs[2]  = '{1'b0, 1'b1, 3'b001, 32'h102, 32'h0000BEEF, 1'b0, 1'b0, 1, 0, 32'h0,        1'b0, 32'h100, 4'hC, 32'hBEEFBEEF, 32'h0};
        vecs[3]  = '{1'b1, 1'b0, 3'b000, 32'h301, 32'h0,        1'b0, 1'b0, 0, 0, 32'h12348056, 1'b0, 32'h300, 4'hF, 32'h0,        32'hFFFFFF80};
        vecs[4]  = '{1'b1, 1'b0, 3'b100, 32'h301, 32'h0,        1'b0, 1'b0, 0, 1, 32'h12348056, 1'b0, 32'h300, 4'hF, 32'h0,        32'h00000080};
        vecs[5]  = '{1'b1, 1'b0, 3'b101, 32'h302, 32'h0,        1'b0, 1'b0, 0, 0, 32'h12348056, 1'b0, 32'h300, 4'hF, 32'h0,        32'h00001234};
        vecs[6]  = '{1'b1, 1'b0, 3'b001, 32'h300, 32'h0,        1'b0, 1'b0, 1, 2, 32'h12348056, 1'b0, 32'h300, 4'hF, 32'h0,        32'hFFFF8056};
        vecs[7]  = '{1'b1, 1'b0, 3'b010, 32'h104, 32'h0,        1'b0, 1'b0, 0, 0, 32'hCAFEF00D, 1'b0, 32'h104, 4'hF, 32'h0,        32'hCAFEF00D};
        vecs[8]  = '{1'b1, 1'b0, 3'b010, 32'h102, 32'h0,        1'b0, 1'b0, 0, 0, 32'h0,        1'b1, 32'h0,   4'h0, 32'h0,        32'h0};
        vecs[9]  = '{1'b1, 1'b0, 3'b011, 32'h100, 32'h0,        1'b0, 1'b0, 0, 0, 32'h0,        1'b1, 32'h0,   4'h0, 32'h0,        32'h0};
        vecs[10] = '{1'b0, 1'b1, 3'b100, 32'h100, 32'h55,       1'b0, 1'b0, 0, 0, 32'h0,        1'b1, 32'h0,   4'h0, 32'h0,        32'h0};
        vecs[11] = '{1'b1, 1'b0, 3'b000, 32'h300, 32'h0,        1'b1, 1'b0, 0, 0, 32'h0,        1'b0, 32'h0,   4'h0, 32'h0,        32'h0};
        vecs[12] = '{1'b1, 1'b0, 3'b000, 32'h303, 32'h0,        1'b0, 1'b1, 1, 1, 32'h7F000000, 1'b0, 32'h300, 4'hF, 32'h0,        32'h0000007F};
        vecs[13] = '{1'b1, 1'b1, 3'b010, 32'h010, 32'h11223344, 1'b0, 1'b0, 0, 0, 32'h0,        1'b0, 32'h010, 4'hF, 32'h11223344, 32'h0};
        vecs[14] = '{1'b1, 1'b0, 3'b101, 32'h301, 32'h0,        1'b0, 1'b0, 0, 0, 32'h0,        1'b1, 32'h0,   4'h0, 32'h0,        32'h0};

        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_reset_outputs(-1);
        rst = 1'b0;

        for (int i = 0; i < NVEC; i++) run_vec(i, vecs[i]);

        // Reset while waiting for read data: transaction is abandoned.
        @(negedge clk);
        m_mem_read = 1'b1;
        funct3     = 3'b010;
        addr       = 32'h200;
        @(negedge clk);
        m_mem_read = 1'b0;
        chk(100, "rw_req", 32'(bus_req), 32'd1);
        bus_gnt = 1'b1;
        @(negedge clk);
        bus_gnt = 1'b0;
        chk(100, "rw_stall_wait", 32'(stall), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_reset_outputs(100);
        bus_rvalid = 1'b1;
        bus_rdata  = 32'h13579BDF;
        @(negedge clk);
        bus_rvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk(100, "rw_no_rvld",  32'(rdata_valid), 32'd0);
            chk(100, "rw_rdata",    rdata, 32'd0);
            chk(100, "rw_no_stall", 32'(stall), 32'd0);
            chk(100, "rw_no_req",   32'(bus_req), 32'd0);
            @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
